// File: rtl/reg_dest_queue_pkg.sv
// Shared definitions for the register-destination queue.
//   SEL_*  : encodings of the destination selector input
//   REG_*  : architectural register indices with fixed meaning
package reg_dest_queue_pkg;

  localparam int SEL_RT = 0;
  localparam int SEL_RD = 1;
  localparam int SEL_SP = 2;
  localparam int SEL_RA = 3;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/reg_dest_queue_sel.sv
// Write-back destination selector (purely combinational).
// Ports:
//   sel      in  destination select
//   rt/rd/rs in  instruction register fields
//   dest_sel out selected destination register index
module reg_dest_sel
  import reg_dest_queue_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 3,
  parameter int SP_IDX = REG_SP,
  parameter int RA_IDX = REG_RA
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  output logic [ADDR_W-1:0] dest_sel
);

  // Any selector value outside the four named encodings falls back to rs.
  always_comb begin
    dest_sel = rs;
    case (sel)
      SEL_W'(SEL_RT): dest_sel = rt;
      SEL_W'(SEL_RD): dest_sel = rd;
      SEL_W'(SEL_SP): dest_sel = ADDR_W'(SP_IDX);
      SEL_W'(SEL_RA): dest_sel = ADDR_W'(RA_IDX);
      default:        dest_sel = rs;
    endcase
  end

endmodule

// File: rtl/reg_dest_queue.sv
// In-order queue of outstanding register write-back destinations.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   sel, rt, rd, rs     destination select and instruction fields
//   dest_sel            combinational selected destination
//   dest_push/dest_pop  enqueue dest_sel / complete the head write-back
//   wb_we, wb_addr      register-file write enable and address (queue head)
//   hazard_rs/rt        rs/rt matches an outstanding non-$0 destination
//   full, empty         occupancy flags
//   push_drop           one-cycle registered pulse: a push was rejected
module reg_dest_queue
  import reg_dest_queue_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 3,
  parameter int SP_IDX = REG_SP,
  parameter int RA_IDX = REG_RA,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  sel,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  output logic [ADDR_W-1:0] dest_sel,
  input  logic              dest_push,
  input  logic              dest_pop,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic              full,
  output logic              empty,
  output logic              push_drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              drop_q, drop_d;
  logic              push_ok, pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  reg_dest_sel #(
    .ADDR_W(ADDR_W), .SEL_W(SEL_W), .SP_IDX(SP_IDX), .RA_IDX(RA_IDX)
  ) u_sel (
    .sel(sel), .rt(rt), .rd(rd), .rs(rs), .dest_sel(dest_sel)
  );

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = dest_pop & ~empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push_ok = dest_push & (~full | pop_ok);

  assign wb_addr   = empty ? '0 : addr_q[head_q];
  assign wb_we     = pop_ok & (wb_addr != ADDR_W'(REG_ZERO));
  assign push_drop = drop_q;

  // Next-state: the push is applied after the pop so that, when full and
  // head == tail, the newly written entry stays valid.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = dest_push & ~push_ok;
    if (pop_ok) begin
      valid_d[head_q] = 1'b0;
      head_d          = nextPtr(head_q);
    end
    if (push_ok) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = dest_sel;
      tail_d          = nextPtr(tail_q);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // State registers; reset discards every outstanding destination.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Hazards look only at registered entries; $0 never hazards.
  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == rs) hazard_rs = 1'b1;
      if (valid_q[i] && addr_q[i] == rt) hazard_rt = 1'b1;
    end
    if (rs == ADDR_W'(REG_ZERO)) hazard_rs = 1'b0;
    if (rt == ADDR_W'(REG_ZERO)) hazard_rt = 1'b0;
  end

endmodule

// File: tb/tb_reg_dest_queue.sv
// Self-checking bench for reg_dest_queue: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_reg_dest_queue;

  localparam int ADDR_W = 5;
  localparam int SEL_W  = 3;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] rt, rd, rs;
  logic [ADDR_W-1:0] dest_sel;
  logic              dest_push, dest_pop;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic              hazard_rs, hazard_rt, full, empty, push_drop;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: outstanding destinations in completion order.
  logic [ADDR_W-1:0] modelQ [$];
  logic              expDrop;

  always #5 clk = ~clk;

  reg_dest_queue #(
    .ADDR_W(ADDR_W), .SEL_W(SEL_W), .SP_IDX(29), .RA_IDX(31), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel), .rt(rt), .rd(rd), .rs(rs),
    .dest_sel(dest_sel), .dest_push(dest_push), .dest_pop(dest_pop),
    .wb_we(wb_we), .wb_addr(wb_addr), .hazard_rs(hazard_rs),
    .hazard_rt(hazard_rt), .full(full), .empty(empty), .push_drop(push_drop)
  );

  function automatic logic [ADDR_W-1:0] refSel();
    case (sel)
      3'd0:    return rt;
      3'd1:    return rd;
      3'd2:    return 5'd29;
      3'd3:    return 5'd31;
      default: return rs;
    endcase
  endfunction

  function automatic logic refHazard(input logic [ADDR_W-1:0] r);
    if (r == 0) return 1'b0;
    foreach (modelQ[i]) if (modelQ[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compares every output against the model for the current inputs.
  task automatic checkOutput();
    logic [ADDR_W-1:0] expAddr;
    logic              popping;
    expAddr = (modelQ.size() > 0) ? modelQ[0] : '0;
    popping = dest_pop && (modelQ.size() > 0);
    compare("dest_sel",  32'(dest_sel),  32'(refSel()));
    compare("wb_addr",   32'(wb_addr),   32'(expAddr));
    compare("wb_we",     32'(wb_we),     32'(popping && expAddr != 0));
    compare("hazard_rs", 32'(hazard_rs), 32'(refHazard(rs)));
    compare("hazard_rt", 32'(hazard_rt), 32'(refHazard(rt)));
    compare("full",      32'(full),      32'(modelQ.size() == DEPTH));
    compare("empty",     32'(empty),     32'(modelQ.size() == 0));
    compare("push_drop", 32'(push_drop), 32'(expDrop));
  endtask

  // Drives one cycle of inputs, checks before the edge, then updates the model.
  task automatic applyStimulus(input int s, input int vrt, input int vrd, input int vrs,
                               input bit push, input bit pop);
    bit popOk, pushOk;
    logic [ADDR_W-1:0] d;
    sel = SEL_W'(s); rt = ADDR_W'(vrt); rd = ADDR_W'(vrd); rs = ADDR_W'(vrs);
    dest_push = push; dest_pop = pop;
    #1;
    checkOutput();
    d      = refSel();
    popOk  = pop && (modelQ.size() > 0);
    pushOk = push && ((modelQ.size() < DEPTH) || popOk);
    @(posedge clk);
    #1;
    if (popOk)  void'(modelQ.pop_front());
    if (pushOk) modelQ.push_back(d);
    expDrop = push && !pushOk;
  endtask

  // Asserts reset between clock edges and checks its immediate effect.
  task automatic midReset();
    dest_push = 1'b0; dest_pop = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    modelQ.delete();
    expDrop = 1'b0;
    checkOutput();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sel = '0; rt = '0; rd = '0; rs = '0;
    dest_push = 1'b0; dest_pop = 1'b0; expDrop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Selector sweep
    for (int s = 0; s < 8; s++) applyStimulus(s, 3, 4, 5, 0, 0);

    // Fill then pop
    applyStimulus(1, 0, 8, 0, 1, 0);
    applyStimulus(0, 9, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Overflow while full
    applyStimulus(1, 0, 8, 0, 1, 0);
    applyStimulus(0, 9, 0, 0, 1, 0);
    applyStimulus(1, 0, 10, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Push and pop together while full
    applyStimulus(1, 0, 12, 0, 1, 1);
    applyStimulus(0, 0, 0, 9, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Hazards and $0
    applyStimulus(1, 0, 7, 0, 1, 0);
    applyStimulus(0, 0, 0, 7, 0, 0);
    applyStimulus(0, 0, 0, 7, 1, 0);
    applyStimulus(0, 0, 0, 7, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset mid-operation
    applyStimulus(1, 0, 14, 0, 1, 0);
    applyStimulus(0, 15, 0, 14, 1, 0);
    midReset();
    applyStimulus(1, 0, 6, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 9) < 5));
      if ($urandom_range(0, 99) == 0) midReset();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
